// File: rtl/acq_scheduler.sv
// Acquisition scheduler: round-robin averaging over four sensors, or an
// ultrasonic trigger/echo ranging cycle, selected by mode while idle.
module acq_scheduler #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TRIG_CYCLES    = 250,
  parameter int ECHO_TIMEOUT   = 60000,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        mode,
  input  logic [7:0]  sensor_data,
  input  logic        echo,
  output logic [1:0]  sensor_sel,
  output logic        sample_valid,
  output logic [1:0]  sample_id,
  output logic [7:0]  sample_avg,
  output logic        trig,
  output logic        dist_valid,
  output logic [15:0] dist_cycles,
  output logic        dist_timeout,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, SETTLE, ACCUM, REPORT, TRIG, WAIT_ECHO, MEASURE, DIST_RPT, HOLDOFF
  } state_t;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TRIG_LAST    = 16'(TRIG_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(ECHO_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(HOLDOFF_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [9:0]  acc;
  logic [9:0]  acc_sum;
  logic        echo_meta;
  logic        echo_s;
  logic        echo_prev;
  logic        echo_rise;

  // Four 8-bit samples peak at 1020, so 10 bits never overflow.
  assign acc_sum   = acc + {2'b00, sensor_data};
  assign echo_rise = echo_s & ~echo_prev;

  // echo is asynchronous; only echo_s may feed the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_prev <= echo_s;
    end
  end

  // NOTE: every register here is assigned with <= so all branches see the
  // pre-edge values; outputs are set on the transition into their state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      sensor_sel   <= '0;
      sample_valid <= 1'b0;
      sample_id    <= '0;
      sample_avg   <= '0;
      trig         <= 1'b0;
      dist_valid   <= 1'b0;
      dist_cycles  <= '0;
      dist_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      dist_valid   <= 1'b0;
      // REPORT has already emitted its pulse, so it finishes normally.
      if (state != IDLE && state != REPORT && !ena) begin
        state <= IDLE;
        busy  <= 1'b0;
        trig  <= 1'b0;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (ena) begin
              busy <= 1'b1;
              if (mode) begin
                state <= TRIG;
                trig  <= 1'b1;
              end else begin
                state <= SETTLE;
              end
            end
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state <= ACCUM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ACCUM: begin
            acc <= acc_sum;
            if (cnt == 16'd3) begin
              state        <= REPORT;
              cnt          <= '0;
              sample_valid <= 1'b1;
              sample_id    <= sensor_sel;
              sample_avg   <= acc_sum[9:2];
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          REPORT: begin
            sensor_sel <= sensor_sel + 2'd1;
            acc        <= '0;
            if (ena && !mode) begin
              state <= SETTLE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          TRIG: begin
            if (cnt == TRIG_LAST) begin
              state <= WAIT_ECHO;
              trig  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          WAIT_ECHO: begin
            if (echo_rise) begin
              state <= MEASURE;
              cnt   <= 16'd1;
            end else if (cnt == TIMEOUT_LAST) begin
              state        <= DIST_RPT;
              dist_valid   <= 1'b1;
              dist_cycles  <= 16'hFFFF;
              dist_timeout <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          MEASURE: begin
            if (!echo_s) begin
              state        <= DIST_RPT;
              dist_valid   <= 1'b1;
              dist_cycles  <= cnt;
              dist_timeout <= 1'b0;
            end else if (cnt == 16'hFFFE) begin
              state        <= DIST_RPT;
              dist_valid   <= 1'b1;
              dist_cycles  <= 16'hFFFF;
              dist_timeout <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DIST_RPT: begin
            state <= HOLDOFF;
            cnt   <= '0;
          end
          HOLDOFF: begin
            if (cnt == HOLD_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            trig  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_scheduler.sv
// Self-checking bench for acq_scheduler: vector table for the averaging,
// a cycle-indexed reference model for scans, and ranging/abort sequences.
module tb_acq_scheduler;

  localparam int SETTLE  = 8;
  localparam int TRIGW   = 250;
  localparam int TIMEOUT = 50;
  localparam int HOLDOFF = 1000;
  localparam int PERIOD  = SETTLE + 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        mode;
  logic [7:0]  sensor_data;
  logic        echo;
  logic [1:0]  sensor_sel;
  logic        sample_valid;
  logic [1:0]  sample_id;
  logic [7:0]  sample_avg;
  logic        trig;
  logic        dist_valid;
  logic [15:0] dist_cycles;
  logic        dist_timeout;
  logic        busy;

  always #5 clk = ~clk;

  acq_scheduler #(
    .SETTLE_CYCLES (SETTLE),
    .TRIG_CYCLES   (TRIGW),
    .ECHO_TIMEOUT  (TIMEOUT),
    .HOLDOFF_CYCLES(HOLDOFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .mode        (mode),
    .sensor_data (sensor_data),
    .echo        (echo),
    .sensor_sel  (sensor_sel),
    .sample_valid(sample_valid),
    .sample_id   (sample_id),
    .sample_avg  (sample_avg),
    .trig        (trig),
    .dist_valid  (dist_valid),
    .dist_cycles (dist_cycles),
    .dist_timeout(dist_timeout),
    .busy        (busy)
  );

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [7:0]      avg;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          n;
  logic [7:0]  hist [0:1023];
  logic [15:0] last_dist;
  vec_t        vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, sensor_sel, sample_valid, sample_id, sample_avg, trig,
            dist_valid, dist_cycles, dist_timeout, busy};
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] e,
                              input logic [7:0] avg);
    vec_t v;
    v.d[0] = a;
    v.d[1] = b;
    v.d[2] = c;
    v.d[3] = e;
    v.avg  = avg;
    return v;
  endfunction

  // Outputs are sampled at the falling edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (sample_valid || dist_valid)
      check("valid_exclusive", 64'(sample_valid & dist_valid), 64'd0);
  endtask

  // One scan cycle against the model: cycle n (1-based since release) of a
  // continuous scan reports in every PERIOD-th cycle the mean of the data
  // presented in the four preceding cycles, sensors in round-robin order.
  task automatic scan_cycle(input logic [7:0] data);
    int k;
    int sum;
    step();
    n++;
    if (n % PERIOD == 0) begin
      k   = n / PERIOD - 1;
      sum = int'(hist[n-4]) + int'(hist[n-3]) + int'(hist[n-2]) + int'(hist[n-1]);
      check("sample_valid", 64'(sample_valid), 64'd1);
      check("sample_id", 64'(sample_id), 64'(k % 4));
      check("sensor_sel", 64'(sensor_sel), 64'(k % 4));
      check("sample_avg", 64'(sample_avg), 64'(sum / 4));
    end else begin
      check("sample_quiet", 64'(sample_valid), 64'd0);
    end
    sensor_data = data;
    hist[n]     = data;
  endtask

  task automatic holdoff_run();
    int cnt;
    step();
    check("dist_pulse_width", 64'(dist_valid), 64'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1200) begin
      cnt++;
      step();
    end
    check("holdoff_len", 64'(cnt), 64'(HOLDOFF));
    check("dist_retained", 64'(dist_cycles), 64'(last_dist));
  endtask

  // w == 0: echo never rises and a timeout report is expected.
  task automatic range_run(input int d, input int w);
    int cnt;
    cnt = 0;
    while (trig !== 1'b1 && cnt < 3000) begin
      step();
      cnt++;
    end
    check("trig_start", 64'(trig), 64'd1);
    cnt = 0;
    while (trig === 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    check("trig_width", 64'(cnt), 64'(TRIGW));
    check("busy_wait", 64'(busy), 64'd1);
    if (w == 0) begin
      cnt = 0;
      while (dist_valid !== 1'b1 && cnt < 100) begin
        step();
        cnt++;
      end
      check("timeout_delay", 64'(cnt), 64'(TIMEOUT));
      check("timeout_flag", 64'(dist_timeout), 64'd1);
      check("timeout_cycles", 64'(dist_cycles), 64'hFFFF);
      last_dist = 16'hFFFF;
    end else begin
      repeat (d) step();
      echo = 1'b1;
      repeat (w) step();
      echo = 1'b0;
      cnt = 0;
      while (dist_valid !== 1'b1 && cnt < 20) begin
        step();
        cnt++;
      end
      check("dist_valid", 64'(dist_valid), 64'd1);
      check("dist_cycles", 64'(dist_cycles), 64'(w));
      check("dist_timeout", 64'(dist_timeout), 64'd0);
      last_dist = 16'(w);
    end
    holdoff_run();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end, want end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int pos;
    logic [7:0] data;

    vecs[0] = mk(8'd1,   8'd2,   8'd3,   8'd4,   8'd2);
    vecs[1] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    vecs[2] = mk(8'd0,   8'd0,   8'd0,   8'd3,   8'd0);
    vecs[3] = mk(8'd200, 8'd201, 8'd202, 8'd203, 8'd201);
    vecs[4] = mk(8'd7,   8'd0,   8'd0,   8'd0,   8'd1);
    vecs[5] = mk(8'd1,   8'd1,   8'd1,   8'd0,   8'd0);

    rst_n = 1'b0;
    ena = 1'b0; mode = 1'b0; echo = 1'b0; sensor_data = 8'd0;
    for (int i = 0; i < 10; i++) begin
      ena         = 1'($urandom);
      mode        = 1'($urandom);
      echo        = 1'($urandom);
      sensor_data = 8'($urandom);
      step();
      check("reset_outs", all_outs(), 64'd0);
    end

    rst_n = 1'b1; ena = 1'b1; mode = 1'b0; echo = 1'b0; sensor_data = 8'd0;
    n = 0;

    // Constant 100 for five samples, then random data.
    for (int i = 0; i < 13 * PERIOD; i++) begin
      data = (i < 5 * PERIOD) ? 8'd100 : 8'($urandom);
      scan_cycle(data);
    end

    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < PERIOD; p++) begin
        pos  = (n + 1) % PERIOD;
        data = (pos >= 9 && pos <= 12) ? vecs[v].d[pos-9] : 8'($urandom);
        scan_cycle(data);
      end
      check("table_avg", 64'(sample_avg), 64'(vecs[v].avg));
    end

    // Mode flips during ACCUM: sample still reported, then IDLE, then TRIG.
    for (int p = 0; p < PERIOD; p++) begin
      if ((n + 1) % PERIOD == 10) mode = 1'b1;
      scan_cycle(8'd40);
    end
    check("toggle_avg", 64'(sample_avg), 64'd40);
    step();
    check("toggle_idle_busy", 64'(busy), 64'd0);
    check("toggle_idle_trig", 64'(trig), 64'd0);
    check("toggle_next_sel", 64'(sensor_sel), 64'(((n / PERIOD)) % 4));
    step();
    check("toggle_trig", 64'(trig), 64'd1);

    range_run(20, 100);
    range_run(0, 0);
    for (int i = 0; i < 3; i++)
      range_run(int'($urandom_range(0, 40)), int'($urandom_range(1, 80)));

    // ena dropped in MEASURE: straight to IDLE, no report.
    cnt = 0;
    while (trig !== 1'b1 && cnt < 3000) begin
      step();
      cnt++;
    end
    cnt = 0;
    while (trig === 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    check("abort_trig_width", 64'(cnt), 64'(TRIGW));
    repeat (5) step();
    echo = 1'b1;
    repeat (30) step();
    ena = 1'b0;
    step();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_no_dist", 64'(dist_valid), 64'd0);
    check("abort_trig", 64'(trig), 64'd0);
    check("abort_dist_kept", 64'(dist_cycles), 64'(last_dist));
    echo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_quiet", 64'({busy, dist_valid}), 64'd0);
    end

    // Reset during TRIG.
    ena = 1'b1; mode = 1'b1;
    cnt = 0;
    while (trig !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    check("rst_trig_start", 64'(trig), 64'd1);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    check("rst_mid_outs", all_outs(), 64'd0);
    rst_n = 1'b1; ena = 1'b0;
    step();
    check("rst_after_idle", 64'({busy, trig}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
